// File: rtl/spram_line_ctrl.sv
// Frame-store controller: streams received pixels into single-port RAM, then
// fetches display lines into ping-pong buffers for the VGA scan-out.
module spram_line_ctrl #(
    parameter int W        = 200,
    parameter int H        = 185,
    parameter int PW       = 12,
    parameter int AW       = 16,
    parameter int RD_LAT   = 1,
    parameter int STARTCOL = 0,
    parameter int BG       = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode_i,
    input  logic          rx_valid_i,
    input  logic [PW-1:0] rx_data_i,
    output logic          frame_done_o,
    output logic          rx_overflow_o,
    input  logic          frame_start_i,
    input  logic          line_req_i,
    input  logic          line_swap_i,
    output logic          line_busy_o,
    output logic          line_ready_o,
    input  logic          display_valid_i,
    input  logic [9:0]    x_addr_i,
    output logic [PW-1:0] pixel_data_o,
    output logic [AW-1:0] spram_addr_o,
    output logic [PW-1:0] spram_wr_data_o,
    output logic          spram_wre_o,
    output logic          spram_ce_o,
    input  logic [PW-1:0] spram_rd_data_i
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = $clog2(H + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(W * H - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    state_t             state_q;
    logic [AW-1:0]      wr_cnt_q, line_ptr_q, addr_q;
    logic [CW-1:0]      line_cnt_q;
    logic [PW-1:0]      wr_data_q;
    logic               frame_done_q, overflow_q, wre_q, busy_q, ready_q;
    logic               front_q, fetch_buf_q, start_pend_q, issuing_q;
    logic [IW-1:0]      iss_idx_q;
    logic [RD_LAT:0]    vld_pipe_q;
    logic [RD_LAT:0][IW-1:0] idx_pipe_q;
    logic [PW-1:0]      lbuf [2][W];

    logic wr_ok, rd_ok, cap, cap_last;
    assign wr_ok    = (state_q == S_WR) && (mode_i == 2'd1);
    assign rd_ok    = (state_q == S_RD) && (mode_i == 2'd2);
    assign cap      = rd_ok && vld_pipe_q[RD_LAT];
    assign cap_last = cap && (idx_pipe_q[RD_LAT] == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_cnt_q     <= '0;
            line_ptr_q   <= '0;
            line_cnt_q   <= '0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            wre_q        <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            front_q      <= 1'b0;
            fetch_buf_q  <= 1'b0;
            start_pend_q <= 1'b0;
            issuing_q    <= 1'b0;
            iss_idx_q    <= '0;
            vld_pipe_q   <= '0;
            idx_pipe_q   <= '0;
        end else begin
            wre_q      <= 1'b0;
            ready_q    <= 1'b0;
            vld_pipe_q <= {vld_pipe_q[RD_LAT-1:0], 1'b0};
            idx_pipe_q <= {idx_pipe_q[RD_LAT-1:0], IW'(0)};
            if (line_swap_i) front_q <= ~front_q;

            case (state_q)
                S_IDLE: begin
                    if (mode_i == 2'd1)      state_q <= S_WR;
                    else if (mode_i == 2'd2) state_q <= S_RD;
                end
                S_WR, S_RD: begin
                    if (!wr_ok && !rd_ok) begin
                        // mode changed: drop everything in flight
                        state_q      <= S_IDLE;
                        wr_cnt_q     <= '0;
                        frame_done_q <= 1'b0;
                        overflow_q   <= 1'b0;
                        busy_q       <= 1'b0;
                        issuing_q    <= 1'b0;
                        vld_pipe_q   <= '0;
                    end else if (wr_ok) begin
                        if (rx_valid_i && frame_done_q) begin
                            overflow_q <= 1'b1;
                        end else if (rx_valid_i) begin
                            wre_q     <= 1'b1;
                            addr_q    <= wr_cnt_q;
                            wr_data_q <= rx_data_i;
                            if (wr_cnt_q == LAST_ADDR) frame_done_q <= 1'b1;
                            else                       wr_cnt_q     <= wr_cnt_q + AW'(1);
                        end
                    end else begin
                        // index 0 goes out on the request edge so latency is W+RD_LAT+1
                        if (line_req_i && !busy_q) begin
                            busy_q        <= 1'b1;
                            fetch_buf_q   <= ~front_q;
                            addr_q        <= line_ptr_q;
                            vld_pipe_q[0] <= 1'b1;
                            idx_pipe_q[0] <= '0;
                            iss_idx_q     <= IW'(1);
                            issuing_q     <= (W > 1);
                        end else if (issuing_q) begin
                            addr_q        <= line_ptr_q + AW'(iss_idx_q);
                            vld_pipe_q[0] <= 1'b1;
                            idx_pipe_q[0] <= iss_idx_q;
                            iss_idx_q     <= iss_idx_q + IW'(1);
                            if (iss_idx_q == LAST_IDX) issuing_q <= 1'b0;
                        end
                        if (cap_last) begin
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            if (start_pend_q || frame_start_i || line_cnt_q == CW'(H - 1)) begin
                                line_ptr_q   <= '0;
                                line_cnt_q   <= '0;
                                start_pend_q <= 1'b0;
                            end else begin
                                line_ptr_q <= line_ptr_q + AW'(W);
                                line_cnt_q <= line_cnt_q + CW'(1);
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // frame_start during a fetch is deferred to the fetch's last capture
            if (!busy_q && (frame_start_i || start_pend_q)) begin
                line_ptr_q   <= '0;
                line_cnt_q   <= '0;
                start_pend_q <= 1'b0;
            end else if (busy_q && frame_start_i && !cap_last) begin
                start_pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap) lbuf[fetch_buf_q][idx_pipe_q[RD_LAT]] <= spram_rd_data_i;
    end

    logic [10:0]   xe;
    logic          inwin;
    logic [IW-1:0] pidx;
    assign xe    = {1'b0, x_addr_i};
    assign inwin = display_valid_i && (xe >= 11'(STARTCOL)) && (xe < 11'(STARTCOL + W));
    assign pidx  = inwin ? IW'(x_addr_i - 10'(STARTCOL)) : '0;

    assign pixel_data_o    = inwin ? lbuf[front_q][pidx] : PW'(BG);
    assign frame_done_o    = frame_done_q;
    assign rx_overflow_o   = overflow_q;
    assign line_busy_o     = busy_q;
    assign line_ready_o    = ready_q;
    assign spram_addr_o    = addr_q;
    assign spram_wr_data_o = wr_data_q;
    assign spram_wre_o     = wre_q;
    assign spram_ce_o      = 1'b1;
endmodule

// File: tb/tb_spram_line_ctrl.sv
// Directed bench for spram_line_ctrl: one RD_LAT=1 and one RD_LAT=3 instance
// share stimulus, each backed by its own RAM model.
module tb_spram_line_ctrl;
    localparam int W = 4, H = 3, PW = 12, AW = 4, STARTCOL = 8, BG = 0;
    localparam int L1 = W + 1 + 1, L3 = W + 3 + 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic rx_valid = 1'b0, frame_start = 1'b0, line_req = 1'b0, line_swap = 1'b0, dv = 1'b0;
    logic [PW-1:0] rx_data = '0;
    logic [9:0] x_addr = '0;

    logic fd1, ov1, busy1, rdy1, wre1, ce1, fd3, ov3, busy3, rdy3, wre3, ce3;
    logic [PW-1:0] pix1, wd1, rd1, pix3, wd3, rd3;
    logic [AW-1:0] addr1, addr3;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    spram_line_ctrl #(.W(W), .H(H), .PW(PW), .AW(AW), .RD_LAT(1), .STARTCOL(STARTCOL), .BG(BG)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .frame_done_o(fd1), .rx_overflow_o(ov1), .frame_start_i(frame_start), .line_req_i(line_req),
        .line_swap_i(line_swap), .line_busy_o(busy1), .line_ready_o(rdy1), .display_valid_i(dv),
        .x_addr_i(x_addr), .pixel_data_o(pix1), .spram_addr_o(addr1), .spram_wr_data_o(wd1),
        .spram_wre_o(wre1), .spram_ce_o(ce1), .spram_rd_data_i(rd1));

    spram_line_ctrl #(.W(W), .H(H), .PW(PW), .AW(AW), .RD_LAT(3), .STARTCOL(STARTCOL), .BG(BG)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode_i(mode), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .frame_done_o(fd3), .rx_overflow_o(ov3), .frame_start_i(frame_start), .line_req_i(line_req),
        .line_swap_i(line_swap), .line_busy_o(busy3), .line_ready_o(rdy3), .display_valid_i(dv),
        .x_addr_i(x_addr), .pixel_data_o(pix3), .spram_addr_o(addr3), .spram_wr_data_o(wd3),
        .spram_wre_o(wre3), .spram_ce_o(ce3), .spram_rd_data_i(rd3));

    logic [PW-1:0] mem1 [16];
    logic [PW-1:0] mem3 [16];
    logic [PW-1:0] p3 [3];
    always @(posedge clk) begin
        if (ce1 && wre1) mem1[addr1] <= wd1;
        rd1 <= mem1[addr1];
    end
    always @(posedge clk) begin
        if (ce3 && wre3) mem3[addr3] <= wd3;
        p3[0] <= mem3[addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd3 = p3[2];

    typedef struct {
        logic       dv;
        logic [9:0] x;
        int         off;   // pixel offset within the line, -1 means background
    } pvec_t;
    pvec_t pv [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int n, input bit extra_req);
        int line;
        logic [31:0] expx;
        line = n % H;
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        for (int c = 1; c <= L3; c++) begin
            if (c <= W) begin
                chk("rd_addr1", addr1, line * W + c - 1);
                chk("rd_addr3", addr3, line * W + c - 1);
                chk("rd_wre1", wre1, 0);
            end
            chk("busy1", busy1, c < L1);
            chk("ready1", rdy1, c == L1);
            chk("busy3", busy3, c < L3);
            chk("ready3", rdy3, c == L3);
            line_req = extra_req && (c == 2);
            if (c < L3) tick();
        end
        line_req = 1'b0;
        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            dv = pv[i].dv;
            x_addr = pv[i].x;
            #1;
            expx = (pv[i].off < 0) ? BG : line * W + pv[i].off + 1;
            chk("pixel1", pix1, expx);
            chk("pixel3", pix3, expx);
        end
        dv = 1'b0;
    endtask

    initial begin
        pv[0] = '{1'b1, 10'd8,  0};
        pv[1] = '{1'b1, 10'd9,  1};
        pv[2] = '{1'b1, 10'd10, 2};
        pv[3] = '{1'b1, 10'd11, 3};
        pv[4] = '{1'b1, 10'd7,  -1};
        pv[5] = '{1'b1, 10'd12, -1};
        pv[6] = '{1'b0, 10'd9,  -1};

        #12;
        chk("rst_fd", fd1, 0);
        chk("rst_ov", ov1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_ready", rdy1, 0);
        chk("rst_wre", wre1, 0);
        chk("rst_ce", ce1, 1);
        chk("rst_ce3", ce3, 1);
        chk("rst_addr", addr1, 0);
        chk("rst_pix", pix1, BG);
        tick();
        rst_n = 1'b1;

        mode = 2'd1;
        tick();
        for (int i = 0; i < W * H; i++) begin
            rx_valid = 1'b1;
            rx_data = PW'(i + 1);
            tick();
            chk("wr_wre", wre1, 1);
            chk("wr_addr", addr1, i);
            chk("wr_data", wd1, i + 1);
            chk("wr_done", fd1, i == W * H - 1);
        end
        rx_data = 12'hFFF;
        tick();
        chk("ovf_wre", wre1, 0);
        chk("ovf_flag", ov1, 1);
        chk("ovf_done", fd1, 1);
        chk("ovf_flag3", ov3, 1);
        rx_valid = 1'b0;
        tick();
        chk("ovf_sticky", ov1, 1);
        mode = 2'd0;
        tick();
        chk("idle_fd", fd1, 0);
        chk("idle_ov", ov1, 0);
        chk("idle_fd3", fd3, 0);

        mode = 2'd2;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fetch(0, 1'b0);
        fetch(1, 1'b1);
        fetch(2, 1'b0);
        fetch(3, 1'b0);

        // abort a fetch after two addresses (line_ptr is back at line 1 = 4)
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        chk("ab_addr0", addr1, 4);
        tick();
        chk("ab_addr1", addr1, 5);
        mode = 2'd0;
        tick();
        chk("ab_busy1", busy1, 0);
        chk("ab_busy3", busy3, 0);
        for (int i = 0; i < 3; i++) begin
            chk("ab_hold1", addr1, 5);
            chk("ab_hold3", addr3, 5);
            chk("ab_rdy1", rdy1, 0);
            chk("ab_rdy3", rdy3, 0);
            tick();
        end

        mode = 2'd1;
        tick();
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1;
            rx_data = PW'(12'h0A0 + i);
            tick();
        end
        chk("mid_addr", addr1, 5);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("arst_wre", wre1, 0);
        chk("arst_addr", addr1, 0);
        chk("arst_data", wd1, 0);
        chk("arst_ce", ce1, 1);
        chk("arst_wre3", wre3, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_wre", wre1, 0);
        rx_valid = 1'b1;
        rx_data = 12'h0B0;
        tick();
        chk("restart_wre", wre1, 1);
        chk("restart_addr", addr1, 0);
        chk("restart_data", wd1, 12'h0B0);
        rx_valid = 1'b0;
        tick();
        chk("restart_idle", wre1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
